lane_fifo: RTL and testbench

- Per-lane elastic buffer placed directly downstream of the 1:2 demux, one instance on each output lane (data_out0/valid_out0 and data_out1/valid_out1).
- Absorbs the demux's bursty, alternating-word output and presents it to the consumer through a pop handshake with registered read data.
- Exports full/empty and programmable almost-full/almost-empty flags for upstream flow control, plus a sticky overflow/underflow error bit.

---
 rtl/lane_fifo_pkg.sv | 22 ++
 rtl/lane_fifo.sv | 88 ++++++++
 tb/tb_lane_fifo.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/lane_fifo_pkg.sv
// Shared defaults for the demux lanes, lane_fifo and the lane checker.
// Keeping the flag thresholds here lets all three agree on them.
package lane_fifo_pkg;

    localparam int unsigned LANE_DATA_W = 8;
    localparam int unsigned LANE_DEPTH  = 4;
    localparam int unsigned LANE_AF_TH  = 3;
    localparam int unsigned LANE_AE_TH  = 1;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lane_fifo.sv
// Per-lane elastic buffer behind the 1:2 demux: pop handshake with registered
// read data, occupancy flags and a sticky overflow/underflow error bit.
module lane_fifo
    import lane_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = LANE_DATA_W,
    parameter int unsigned DEPTH  = LANE_DEPTH,
    parameter int unsigned AF_TH  = LANE_AF_TH,
    parameter int unsigned AE_TH  = LANE_AE_TH
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              push,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              err
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    logic do_wr;
    logic do_rd;
    logic err_set;

    // Flags decode the registered count directly.
    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == CW'(0));
    assign almost_full  = (count >= CW'(AF_TH));
    assign almost_empty = (count <= CW'(AE_TH));

    // A read frees a slot in the same edge, so a full FIFO still accepts a
    // push alongside a pop; an empty FIFO never bypasses the write to the read.
    always_comb begin
        do_rd   = 1'b0;
        do_wr   = 1'b0;
        err_set = 1'b0;
        do_rd   = pop && !empty;
        do_wr   = push && (!full || do_rd);
        err_set = (push && full && !pop) || (pop && empty);
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_L) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            err       <= 1'b0;
        end else begin
            valid_out <= do_rd;
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr   <= rd_ptr + AW'(1);
                data_out <= mem[rd_ptr];
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lane_fifo.sv
// Directed bench for lane_fifo: a vector table for reset/fill/drain plus
// hand-written sequences for full push+pop, overflow, underflow and reset.
module tb_lane_fifo;

    logic       clk;
    logic       reset_L;
    logic       push;
    logic [7:0] data_in;
    logic       pop;
    logic [7:0] data_out;
    logic       valid_out;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       err;

    int tests;
    int fails;

    lane_fifo #(
        .DATA_W(8),
        .DEPTH (4),
        .AF_TH (3),
        .AE_TH (1)
    ) dut (
        .clk         (clk),
        .reset_L     (reset_L),
        .push        (push),
        .data_in     (data_in),
        .pop         (pop),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       psh;
        logic [7:0] din;
        logic       pp;
        logic       v;
        logic [7:0] d;
        logic       f;
        logic       e;
        logic       af;
        logic       ae;
        logic       er;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive away from the active edge, then sample 1 time unit after it.
    task automatic step(input logic r, input logic p, input logic [7:0] d, input logic q);
        @(negedge clk);
        reset_L = r;
        push    = p;
        data_in = d;
        pop     = q;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string name, input logic v, input logic [7:0] d,
                              input logic f, input logic e, input logic af,
                              input logic ae, input logic er);
        chk({name, ".valid"}, 8'(valid_out), 8'(v));
        chk({name, ".data"}, data_out, d);
        chk({name, ".full"}, 8'(full), 8'(f));
        chk({name, ".empty"}, 8'(empty), 8'(e));
        chk({name, ".afull"}, 8'(almost_full), 8'(af));
        chk({name, ".aempty"}, 8'(almost_empty), 8'(ae));
        chk({name, ".err"}, 8'(err), 8'(er));
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tests   = 0;
        fails   = 0;
        reset_L = 1'b1;
        push    = 1'b0;
        data_in = 8'h00;
        pop     = 1'b0;

        //          name       rst  psh din    pop  v    d      f    e    af   ae   err
        vecs[0]  = '{"rst0",   1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{"rst1",   1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{"idle",   1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{"pushFF", 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{"pushEE", 1'b0, 1'b1, 8'hEE, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{"pushDD", 1'b0, 1'b1, 8'hDD, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{"pushCC", 1'b0, 1'b1, 8'hCC, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{"hold",   1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{"pop1",   1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{"pop2",   1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{"gap",    1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{"pop3",   1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hDD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{"pop4",   1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hCC, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{"drained",1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hCC, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{"idle2",  1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hCC, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].rst, vecs[i].psh, vecs[i].din, vecs[i].pp);
            expect_all(vecs[i].name, vecs[i].v, vecs[i].d, vecs[i].f, vecs[i].e,
                       vecs[i].af, vecs[i].ae, vecs[i].er);
        end

        // Full FIFO: simultaneous push and pop keeps it full without error.
        step(1'b0, 1'b1, 8'hFF, 1'b0);
        step(1'b0, 1'b1, 8'hEE, 1'b0);
        step(1'b0, 1'b1, 8'hDD, 1'b0);
        step(1'b0, 1'b1, 8'hCC, 1'b0);
        expect_all("A.fill", 1'b0, 8'hCC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h55, 1'b1);
        expect_all("A.pushpop", 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        expect_all("A.popEE", 1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        expect_all("A.popDD", 1'b1, 8'hDD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        expect_all("A.popCC", 1'b1, 8'hCC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        expect_all("A.pop55", 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Overflow: the dropped word must never come out.
        step(1'b0, 1'b1, 8'h11, 1'b0);
        step(1'b0, 1'b1, 8'h22, 1'b0);
        step(1'b0, 1'b1, 8'h33, 1'b0);
        step(1'b0, 1'b1, 8'h44, 1'b0);
        step(1'b0, 1'b1, 8'h77, 1'b0);
        expect_all("B.ovf", 1'b0, 8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        expect_all("B.pop11", 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        expect_all("B.pop22", 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        expect_all("B.pop33", 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        expect_all("B.pop44", 1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        expect_all("B.rst", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Underflow, then push+pop on an empty FIFO (no bypass).
        step(1'b0, 1'b0, 8'h00, 1'b1);
        expect_all("C.udf", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 8'h03, 1'b1);
        expect_all("C.pushpop", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        expect_all("C.pop03", 1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        expect_all("C.rst", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Reset mid-burst discards stored words and restarts the pointers.
        step(1'b0, 1'b1, 8'hAA, 1'b0);
        step(1'b0, 1'b1, 8'h99, 1'b0);
        step(1'b0, 1'b1, 8'h07, 1'b0);
        expect_all("D.load", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        expect_all("D.rst", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        expect_all("D.pop", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 8'h08, 1'b0);
        expect_all("D.push08", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        expect_all("D.pop08", 1'b1, 8'h08, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
